uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 146 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Message-atomic round-robin arbiter sharing one UART TX FIFO write port among
// NUM_REQ byte-stream requesters, with burst-limit and idle-timeout release.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          tx_valid_o,
  output logic [DATA_WIDTH-1:0]         tx_data_o,
  input  logic                          tx_ready_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o,
  output logic                          forced_rel_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam int TW = $clog2(IDLE_TIMEOUT) + 1;
  localparam logic [BW-1:0] BURST_LAST   = BW'(MAX_BURST - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(IDLE_TIMEOUT - 1);
  localparam logic [IW-1:0] OWNER_MAX    = IW'(NUM_REQ - 1);

  typedef enum logic {S_IDLE, S_XFER} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
  logic [TW-1:0]   idle_cnt_q, idle_cnt_d;

  logic [DATA_WIDTH-1:0] req_bytes [NUM_REQ];
  logic [IW-1:0]   winner;
  logic            found;
  logic [IW:0]     cand;
  logic            handshake;
  logic            release_now;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_bytes[i] = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Rotating-priority scan starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    winner = rr_ptr_q;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(NUM_REQ)) begin
        cand = cand - (IW+1)'(NUM_REQ);
      end
      if (!found && req_valid_i[cand[IW-1:0]]) begin
        found  = 1'b1;
        winner = cand[IW-1:0];
      end
    end
  end

  // Transfer rule on the TX side: a byte moves on any cycle where
  // tx_valid_o && tx_ready_i; valid never waits on ready, and only the owner sees ready.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    burst_cnt_d  = burst_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    tx_valid_o   = 1'b0;
    tx_data_o    = '0;
    req_ready_o  = '0;
    grant_o      = '0;
    busy_o       = 1'b0;
    forced_rel_o = 1'b0;
    handshake    = 1'b0;
    release_now  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          owner_d     = winner;
          burst_cnt_d = '0;
          idle_cnt_d  = '0;
          state_d     = S_XFER;
        end
      end
      S_XFER: begin
        busy_o               = 1'b1;
        grant_o[owner_q]     = 1'b1;
        tx_valid_o           = req_valid_i[owner_q];
        tx_data_o            = req_bytes[owner_q];
        req_ready_o[owner_q] = tx_ready_i;
        handshake            = req_valid_i[owner_q] && tx_ready_i;

        if (handshake) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
          idle_cnt_d  = '0;
          if (req_last_i[owner_q]) begin
            release_now = 1'b1;
          end else if (burst_cnt_q == BURST_LAST) begin
            release_now  = 1'b1;
            forced_rel_o = 1'b1;
          end
        end else if (!req_valid_i[owner_q]) begin
          // Backpressure (valid high, ready low) deliberately leaves both counters alone.
          if (idle_cnt_q == TIMEOUT_LAST) begin
            release_now  = 1'b1;
            forced_rel_o = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end

        if (release_now) begin
          rr_ptr_d = (owner_q == OWNER_MAX) ? '0 : owner_q + 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      idle_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: inputs change on the falling edge and
// outputs are checked 1ns later, away from the rising edge that updates state.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [3:0]  grant;
  logic        busy;
  logic        forced;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];

  uart_tx_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(16), .IDLE_TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
    .req_ready_o(req_ready),
    .tx_valid_o(tx_valid), .tx_data_o(tx_data), .tx_ready_i(tx_ready),
    .grant_o(grant), .busy_o(busy), .forced_rel_o(forced)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    req_valid = 4'b1111;
    #1;
    tests_run++;
    if (grant !== 4'b0 || busy !== 1'b0 || forced !== 1'b0 || tx_valid !== 1'b0 ||
        req_ready !== 4'b0 || tx_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_outputs: grant=%b busy=%b forced=%b tx_valid=%b ready=%b data=%h, all zero required",
               grant, busy, forced, tx_valid, req_ready, tx_data);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (grant !== 4'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_holds_idle: grant=%b busy=%b while rst high, 0 required", grant, busy);
    end
    rst = 1'b0; req_valid = '0;
  endtask

  task automatic test_single;
    logic [7:0] bytes [0:2];
    logic [7:0] exp;
    bytes = '{8'h41, 8'h42, 8'h43};
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(bytes[i]);
    @(negedge clk);
    req_valid = 4'b0010; req_data[15:8] = 8'h41; req_last = 4'b0000;
    #1;
    tests_run++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_latency: grant=%b busy=%b on request cycle, 0000/0 required", grant, busy);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_data[15:8] = bytes[i];
      req_last = (i == 2) ? 4'b0010 : 4'b0000;
      #1;
      exp = exp_q.pop_front();
      tests_run++;
      if (grant !== 4'b0010 || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL single_grant byte %0d: grant=%b busy=%b, 0010/1 required", i, grant, busy);
      end
      tests_run++;
      if (tx_valid !== 1'b1 || req_ready !== 4'b0010 || tx_data !== exp) begin
        tests_failed++;
        $display("FAIL single_data byte %0d: valid=%b ready=%b data=%h, 1/0010/%h required",
                 i, tx_valid, req_ready, tx_data, exp);
      end
      tests_run++;
      if (forced !== 1'b0) begin
        tests_failed++;
        $display("FAIL single_forced byte %0d: forced=%b, 0 required", i, forced);
      end
    end
    @(negedge clk);
    req_valid = '0; req_last = '0;
    #1;
    tests_run++;
    if (grant !== 4'b0 || busy !== 1'b0 || forced !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_release: grant=%b busy=%b forced=%b, 0000/0/0 required", grant, busy, forced);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_g [0:9];
    logic [7:0] exp_d;
    exp_g = '{4'b0000, 4'b0001, 4'b0000, 4'b0100, 4'b0000,
              4'b0001, 4'b0000, 4'b0100, 4'b0000, 4'b1000};
    do_reset();
    req_data[7:0] = 8'hA0; req_data[23:16] = 8'hA2; req_data[31:24] = 8'hA3;
    req_last = 4'b1111;
    for (int m = 0; m < 10; m++) begin
      @(negedge clk);
      req_valid = (m >= 6) ? 4'b1101 : 4'b0101;
      #1;
      tests_run++;
      if (grant !== exp_g[m] || req_ready !== exp_g[m]) begin
        tests_failed++;
        $display("FAIL rr_grant step %0d: grant=%b ready=%b, %b required", m, grant, req_ready, exp_g[m]);
      end
      if (exp_g[m] != 4'b0000) begin
        exp_d = exp_g[m][0] ? 8'hA0 : (exp_g[m][2] ? 8'hA2 : 8'hA3);
        tests_run++;
        if (tx_data !== exp_d || tx_valid !== 1'b1) begin
          tests_failed++;
          $display("FAIL rr_data step %0d: data=%h valid=%b, %h/1 required", m, tx_data, tx_valid, exp_d);
        end
      end
    end
    @(negedge clk);
    req_valid = '0; req_last = '0;
  endtask

  task automatic test_burst;
    int n3, n0;
    logic [7:0] exp;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'hB0);
    for (int i = 16; i < 20; i++) exp_q.push_back(8'(i));
    n3 = 0; n0 = 0;
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      req_valid[3] = (n3 < 20); req_data[31:24] = 8'(n3); req_last[3] = (n3 == 19);
      req_valid[0] = (c >= 1 && n0 < 1); req_data[7:0] = 8'hB0; req_last[0] = 1'b1;
      #1;
      if (tx_valid && tx_ready) begin
        exp = exp_q.pop_front();
        tests_run++;
        if (tx_data !== exp) begin
          tests_failed++;
          $display("FAIL burst_order cycle %0d: data=%h, %h required", c, tx_data, exp);
        end
        tests_run++;
        if (forced !== (exp == 8'h0F)) begin
          tests_failed++;
          $display("FAIL burst_forced byte %h: forced=%b, %b required", exp, forced, (exp == 8'h0F));
        end
        if (grant[3]) n3++;
        if (grant[0]) n0++;
      end else begin
        tests_run++;
        if (forced !== 1'b0) begin
          tests_failed++;
          $display("FAIL burst_forced_idle cycle %0d: forced=%b, 0 required", c, forced);
        end
      end
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL burst_complete: %0d bytes outstanding, 0 required", exp_q.size());
    end
    @(negedge clk);
    req_valid = '0; req_last = '0;
    #1;
    tests_run++;
    if (grant !== 4'b0) begin
      tests_failed++;
      $display("FAIL burst_release: grant=%b, 0000 required", grant);
    end
  endtask

  task automatic test_backpressure;
    int n1;
    logic [7:0] exp;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(8'hC0 + 8'(i));
    n1 = 0;
    for (int c = 0; c < 120 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      req_valid = (n1 < 4) ? 4'b0010 : 4'b0000;
      req_data[15:8] = 8'hC0 + 8'(n1);
      req_last = (n1 == 3) ? 4'b0010 : 4'b0000;
      tx_ready = !(c >= 2 && c < 102);
      #1;
      if (!tx_ready) begin
        tests_run++;
        if (req_ready !== 4'b0 || tx_valid !== 1'b1 || tx_data !== 8'hC1 ||
            grant !== 4'b0010 || forced !== 1'b0) begin
          tests_failed++;
          $display("FAIL bp_stall cycle %0d: ready=%b valid=%b data=%h grant=%b forced=%b, 0000/1/c1/0010/0 required",
                   c, req_ready, tx_valid, tx_data, grant, forced);
        end
      end else if (tx_valid) begin
        exp = exp_q.pop_front();
        tests_run++;
        if (tx_data !== exp || req_ready !== 4'b0010) begin
          tests_failed++;
          $display("FAIL bp_data cycle %0d: data=%h ready=%b, %h/0010 required", c, tx_data, req_ready, exp);
        end
        n1++;
      end
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL bp_complete: %0d bytes outstanding, 0 required", exp_q.size());
    end
    @(negedge clk);
    req_valid = '0; req_last = '0; tx_ready = 1'b1;
    #1;
    tests_run++;
    if (grant !== 4'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_release: grant=%b busy=%b, 0000/0 required", grant, busy);
    end
  endtask

  task automatic test_last_at_limit;
    do_reset();
    @(negedge clk);
    req_valid = 4'b0010; req_data[15:8] = 8'h60; req_last = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      req_data[15:8] = 8'h60 + 8'(i);
      req_last = (i == 15) ? 4'b0010 : 4'b0000;
      #1;
      tests_run++;
      if (tx_data !== 8'h60 + 8'(i) || grant !== 4'b0010 || forced !== 1'b0) begin
        tests_failed++;
        $display("FAIL limit_last byte %0d: data=%h grant=%b forced=%b, %h/0010/0 required",
                 i, tx_data, grant, forced, 8'h60 + 8'(i));
      end
    end
    @(negedge clk);
    req_valid = '0; req_last = '0;
    #1;
    tests_run++;
    if (grant !== 4'b0) begin
      tests_failed++;
      $display("FAIL limit_release: grant=%b, 0000 required", grant);
    end
  endtask

  task automatic test_timeout;
    do_reset();
    @(negedge clk);
    req_valid = 4'b0100; req_data[23:16] = 8'hD0; req_last = '0;
    @(negedge clk);
    #1;
    tests_run++;
    if (grant !== 4'b0100 || tx_valid !== 1'b1 || tx_data !== 8'hD0) begin
      tests_failed++;
      $display("FAIL to_first: grant=%b valid=%b data=%h, 0100/1/d0 required", grant, tx_valid, tx_data);
    end
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      req_valid = '0;
      #1;
      tests_run++;
      if (grant !== 4'b0100 || forced !== (k == 63)) begin
        tests_failed++;
        $display("FAIL to_wait idle %0d: grant=%b forced=%b, 0100/%b required", k, grant, forced, (k == 63));
      end
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (grant !== 4'b0 || busy !== 1'b0 || forced !== 1'b0) begin
      tests_failed++;
      $display("FAIL to_release: grant=%b busy=%b forced=%b, 0000/0/0 required", grant, busy, forced);
    end
  endtask

  // Runs after test_timeout, so the rotation pointer starts at 3 here.
  task automatic test_reset_mid;
    @(negedge clk);
    req_valid = 4'b0001; req_data[7:0] = 8'hE0; req_last = '0; tx_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      req_data[7:0] = 8'hE0 + 8'(i);
      #1;
      tests_run++;
      if (grant !== 4'b0001 || tx_data !== 8'hE0 + 8'(i)) begin
        tests_failed++;
        $display("FAIL rm_pre byte %0d: grant=%b data=%h, 0001/%h required", i, grant, tx_data, 8'hE0 + 8'(i));
      end
    end
    @(negedge clk);
    req_data[7:0] = 8'hE2; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b1001; req_data[7:0] = 8'hE0; req_data[31:24] = 8'hF3; req_last = 4'b1000;
    #1;
    tests_run++;
    if (grant !== 4'b0 || tx_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0 ||
        tx_data !== 8'h00 || forced !== 1'b0) begin
      tests_failed++;
      $display("FAIL rm_after: grant=%b valid=%b busy=%b ready=%b data=%h forced=%b, all zero required",
               grant, tx_valid, busy, req_ready, tx_data, forced);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_data[7:0] = 8'hE0 + 8'(i);
      req_last[0] = (i == 4);
      #1;
      tests_run++;
      if (grant !== 4'b0001 || req_ready !== 4'b0001 || tx_data !== 8'hE0 + 8'(i)) begin
        tests_failed++;
        $display("FAIL rm_regrant byte %0d: grant=%b ready=%b data=%h, 0001/0001/%h required",
                 i, grant, req_ready, tx_data, 8'hE0 + 8'(i));
      end
    end
    @(negedge clk);
    req_valid = 4'b1000; req_last = 4'b1000;
    #1;
    tests_run++;
    if (grant !== 4'b0) begin
      tests_failed++;
      $display("FAIL rm_gap: grant=%b, 0000 required", grant);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (grant !== 4'b1000 || tx_data !== 8'hF3) begin
      tests_failed++;
      $display("FAIL rm_next_owner: grant=%b data=%h, 1000/f3 required", grant, tx_data);
    end
    @(negedge clk);
    req_valid = '0; req_last = '0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_burst();
    test_backpressure();
    test_last_at_limit();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
